apb_cmd_master: RTL and testbench

- APB initiator that turns a valid/ready command stream into APB transfers toward APB slave ports such as the input-buffer port.
- Commands are queued in a small FIFO. Each one is issued as a SETUP/ACCESS APB transfer.
- Every command returns exactly one response: read data, or write completion.
- A per-transfer timeout guards against a slave that never raises pready.

---
 rtl/apb_cmd_master.sv | 160 ++++++++++++++++
 tb/tb_apb_cmd_master.sv | 499 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
`timescale 1ns/1ps
// apb_cmd_master: queues valid/ready commands in a small FIFO and issues each
// one as an APB SETUP/ACCESS transfer, returning exactly one response per
// command (read data or write completion), with a per-transfer pready timeout.
module apb_cmd_master #(
   parameter int AW             = 6,
   parameter int DW             = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          cmd_vld_i,
   output logic          cmd_rdy_o,
   input  logic          cmd_write_i,
   input  logic [AW-1:0] cmd_addr_i,
   input  logic [DW-1:0] cmd_wdata_i,
   output logic          rsp_vld_o,
   input  logic          rsp_rdy_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_write_o,
   output logic          rsp_timeout_o,
   output logic [AW-1:0] apb_paddr_m,
   output logic          apb_pwrite_m,
   output logic          apb_psel_m,
   output logic          apb_penable_m,
   output logic [DW-1:0] apb_pwdata_m,
   input  logic [DW-1:0] apb_prdata_m,
   input  logic          apb_pready_m,
   output logic          busy_o
);

   localparam int          PW       = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
   localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t          state;
   logic [15:0]     tcnt;

   logic            fifo_write [FIFO_DEPTH];
   logic [AW-1:0]   fifo_addr  [FIFO_DEPTH];
   logic [DW-1:0]   fifo_wdata [FIFO_DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW:0]     count;

   logic            fifo_empty;
   logic            push;
   logic            pop;

   // Ready depends only on the registered count, so a full FIFO never
   // accepts a push even in a cycle that pops.
   assign cmd_rdy_o  = (count != FULL_CNT);
   assign fifo_empty = (count == '0);
   assign push       = cmd_vld_i && cmd_rdy_o;
   assign pop        = !fifo_empty &&
                       ((state == S_IDLE) || ((state == S_RESP) && rsp_rdy_i));
   assign busy_o     = !fifo_empty || (state != S_IDLE);

   // Command storage; contents need no reset since count gates every read.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_write[wr_ptr] <= cmd_write_i;
         fifo_addr[wr_ptr]  <= cmd_addr_i;
         fifo_wdata[wr_ptr] <= cmd_wdata_i;
      end
   end

   // FIFO pointers and occupancy count.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   // Transfer FSM with registered APB and response outputs.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state         <= S_IDLE;
         tcnt          <= '0;
         apb_paddr_m   <= '0;
         apb_pwrite_m  <= 1'b0;
         apb_psel_m    <= 1'b0;
         apb_penable_m <= 1'b0;
         apb_pwdata_m  <= '0;
         rsp_vld_o     <= 1'b0;
         rsp_rdata_o   <= '0;
         rsp_write_o   <= 1'b0;
         rsp_timeout_o <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state <= S_IDLE;
            end
            S_SETUP: begin
               apb_penable_m <= 1'b1;
               state         <= S_ACCESS;
            end
            S_ACCESS: begin
               if (apb_pready_m) begin
                  apb_psel_m    <= 1'b0;
                  apb_penable_m <= 1'b0;
                  rsp_vld_o     <= 1'b1;
                  rsp_write_o   <= apb_pwrite_m;
                  rsp_rdata_o   <= apb_pwrite_m ? '0 : apb_prdata_m;
                  rsp_timeout_o <= 1'b0;
                  state         <= S_RESP;
               end else if (tcnt == TO_LAST) begin
                  apb_psel_m    <= 1'b0;
                  apb_penable_m <= 1'b0;
                  rsp_vld_o     <= 1'b1;
                  rsp_write_o   <= apb_pwrite_m;
                  rsp_rdata_o   <= '0;
                  rsp_timeout_o <= 1'b1;
                  state         <= S_RESP;
               end else begin
                  tcnt <= tcnt + 16'd1;
               end
            end
            S_RESP: begin
               if (rsp_rdy_i) begin
                  rsp_vld_o <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // A pop starts the next transfer from both IDLE and RESP; placing it
         // after the case lets it override the RESP->IDLE default.
         if (pop) begin
            state         <= S_SETUP;
            tcnt          <= '0;
            apb_psel_m    <= 1'b1;
            apb_penable_m <= 1'b0;
            apb_paddr_m   <= fifo_addr[rd_ptr];
            apb_pwrite_m  <= fifo_write[rd_ptr];
            apb_pwdata_m  <= fifo_write[rd_ptr] ? fifo_wdata[rd_ptr] : '0;
         end
      end
   end

endmodule

// File: tb/tb_apb_cmd_master.sv
`timescale 1ns/1ps
// Testbench for apb_cmd_master: behavioural APB slave with per-transfer wait
// states plus a response model derived from command order and the timeout rule.
module tb_apb_cmd_master;

   localparam int AW    = 6;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int TO    = 8;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int unsigned   wt;
   } cmd_t;

   typedef struct packed {
      logic          write;
      logic [DW-1:0] rdata;
      logic          timeout;
   } rsp_t;

   logic          clk_i = 1'b0;
   logic          rst_n_i;
   logic          cmd_vld_i;
   logic          cmd_rdy_o;
   logic          cmd_write_i;
   logic [AW-1:0] cmd_addr_i;
   logic [DW-1:0] cmd_wdata_i;
   logic          rsp_vld_o;
   logic          rsp_rdy_i;
   logic [DW-1:0] rsp_rdata_o;
   logic          rsp_write_o;
   logic          rsp_timeout_o;
   logic [AW-1:0] apb_paddr_m;
   logic          apb_pwrite_m;
   logic          apb_psel_m;
   logic          apb_penable_m;
   logic [DW-1:0] apb_pwdata_m;
   logic [DW-1:0] apb_prdata_m;
   logic          apb_pready_m;
   logic          busy_o;

   int errors = 0;
   int checks = 0;

   // slave and model state
   logic [DW-1:0] slave_mem [64];
   logic [DW-1:0] model_mem [64];
   bit            mem_init_done;
   int            wait_q[$];
   logic [AW-1:0] bus_addr_q[$];
   rsp_t          exp_q[$];
   int            cur_wait = 0;
   int            acc_cnt  = 0;
   int            sl_w;
   logic          noise    = 1'b0;
   bit            noise_en = 1'b0;

   always #5 clk_i = ~clk_i;

   apb_cmd_master #(
      .AW(AW),
      .DW(DW),
      .FIFO_DEPTH(DEPTH),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk_i(clk_i),
      .rst_n_i(rst_n_i),
      .cmd_vld_i(cmd_vld_i),
      .cmd_rdy_o(cmd_rdy_o),
      .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i),
      .cmd_wdata_i(cmd_wdata_i),
      .rsp_vld_o(rsp_vld_o),
      .rsp_rdy_i(rsp_rdy_i),
      .rsp_rdata_o(rsp_rdata_o),
      .rsp_write_o(rsp_write_o),
      .rsp_timeout_o(rsp_timeout_o),
      .apb_paddr_m(apb_paddr_m),
      .apb_pwrite_m(apb_pwrite_m),
      .apb_psel_m(apb_psel_m),
      .apb_penable_m(apb_penable_m),
      .apb_pwdata_m(apb_pwdata_m),
      .apb_prdata_m(apb_prdata_m),
      .apb_pready_m(apb_pready_m),
      .busy_o(busy_o)
   );

   function automatic logic [DW-1:0] init_val(int i);
      if (i == 60) return 32'h1;
      return 32'(i) * 32'h9E3779B1 + 32'h1234;
   endfunction

   // Behavioural APB slave: wait states chosen per transfer from wait_q.
   always @(posedge clk_i) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 64; i++) slave_mem[i] <= init_val(i);
         mem_init_done <= 1'b1;
      end else if (apb_psel_m && apb_penable_m && apb_pready_m && apb_pwrite_m) begin
         slave_mem[apb_paddr_m] <= apb_pwdata_m;
      end
      if (apb_psel_m && !apb_penable_m) begin
         if (wait_q.size() > 0) sl_w = wait_q.pop_front();
         else sl_w = 0;
         cur_wait <= sl_w;
         acc_cnt  <= 0;
         bus_addr_q.push_back(apb_paddr_m);
      end else if (apb_psel_m && apb_penable_m) begin
         acc_cnt <= acc_cnt + 1;
      end
      noise <= noise_en ? 1'($urandom & 1) : 1'b0;
   end

   assign apb_pready_m = (apb_psel_m && apb_penable_m) ? (acc_cnt == cur_wait) : noise;
   assign apb_prdata_m = slave_mem[apb_paddr_m];

   // Reference: a transfer times out when its wait exceeds the allowed ACCESS
   // cycles; otherwise reads return memory content and writes update it.
   function automatic rsp_t model_rsp(cmd_t c);
      rsp_t r;
      r.write = c.write;
      if (c.wt >= TO) begin
         r.timeout = 1'b1;
         r.rdata   = '0;
      end else begin
         r.timeout = 1'b0;
         if (c.write) begin
            model_mem[c.addr] = c.wdata;
            r.rdata = '0;
         end else begin
            r.rdata = model_mem[c.addr];
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Presents a command and returns one cycle after it is accepted (valid left high).
   task automatic send_cmd(input cmd_t c, output logic ok);
      cmd_vld_i   = 1'b1;
      cmd_write_i = c.write;
      cmd_addr_i  = c.addr;
      cmd_wdata_i = c.wdata;
      ok = 1'b0;
      for (int i = 0; i < 300 && !cmd_rdy_o; i++) tick();
      if (!cmd_rdy_o) return;
      tick();
      exp_q.push_back(model_rsp(c));
      wait_q.push_back(int'(c.wt));
      ok = 1'b1;
   endtask

   // Waits for a response, holds ready low for 'hold' cycles, then handshakes.
   task automatic get_rsp(input int hold, output logic got, output rsp_t r, output rsp_t r_hs);
      got = 1'b0;
      r = '0;
      r_hs = '0;
      for (int i = 0; i < 300 && !rsp_vld_o; i++) tick();
      if (!rsp_vld_o) return;
      r = {rsp_write_o, rsp_rdata_o, rsp_timeout_o};
      repeat (hold) tick();
      r_hs = {rsp_write_o, rsp_rdata_o, rsp_timeout_o};
      rsp_rdy_i = 1'b1;
      tick();
      rsp_rdy_i = 1'b0;
      got = 1'b1;
   endtask

   task automatic test_reset();
      logic [3*DW+AW+6:0] outs;
      rst_n_i = 1'b0;
      cmd_vld_i = 1'b0; cmd_write_i = 1'b0; cmd_addr_i = '0; cmd_wdata_i = '0;
      rsp_rdy_i = 1'b0;
      repeat (3) @(posedge clk_i);
      #1;
      outs = {rsp_vld_o, rsp_rdata_o, rsp_write_o, rsp_timeout_o, apb_paddr_m,
              apb_pwrite_m, apb_psel_m, apb_penable_m, apb_pwdata_m, busy_o, 32'h0};
      checks++;
      if (outs !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h required 0", outs);
      end
      rst_n_i = 1'b1;
      tick();
      checks++;
      if (cmd_rdy_o !== 1'b1) begin
         errors++; $display("FAIL reset_cmd_rdy: got %b required 1", cmd_rdy_o);
      end
      checks++;
      if (busy_o !== 1'b0 || rsp_vld_o !== 1'b0) begin
         errors++; $display("FAIL reset_idle: busy=%b rsp_vld=%b required 0 0", busy_o, rsp_vld_o);
      end
   endtask

   task automatic test_single_write();
      cmd_t c;
      logic ok, got;
      rsp_t r, rh, e;
      c = '{write: 1'b1, addr: 6'h24, wdata: 32'hA5, wt: 0};
      send_cmd(c, ok);
      cmd_vld_i = 1'b0;
      checks++;
      if (ok !== 1'b1) begin errors++; $display("FAIL sw_accept: got %b required 1", ok); end
      checks++;
      if (apb_psel_m !== 1'b0) begin errors++; $display("FAIL sw_psel_t1: got %b required 0", apb_psel_m); end
      tick();
      checks++;
      if ({apb_psel_m, apb_penable_m} !== 2'b10) begin
         errors++; $display("FAIL sw_setup: got %b required 10", {apb_psel_m, apb_penable_m});
      end
      checks++;
      if ({apb_paddr_m, apb_pwrite_m, apb_pwdata_m} !== {6'h24, 1'b1, 32'hA5}) begin
         errors++; $display("FAIL sw_setup_bus: got %h/%b/%h required 24/1/a5", apb_paddr_m, apb_pwrite_m, apb_pwdata_m);
      end
      tick();
      checks++;
      if ({apb_psel_m, apb_penable_m, apb_paddr_m} !== {2'b11, 6'h24}) begin
         errors++; $display("FAIL sw_access: got %b%b/%h required 11/24", apb_psel_m, apb_penable_m, apb_paddr_m);
      end
      tick();
      checks++;
      if ({apb_psel_m, apb_penable_m, rsp_vld_o} !== 3'b001) begin
         errors++; $display("FAIL sw_resp_state: got %b required 001", {apb_psel_m, apb_penable_m, rsp_vld_o});
      end
      get_rsp(0, got, r, rh);
      e = exp_q.pop_front();
      checks++;
      if (got !== 1'b1 || r !== e || r !== {1'b1, 32'h0, 1'b0}) begin
         errors++; $display("FAIL sw_rsp: got %h required %h", r, e);
      end
      checks++;
      if (rsp_vld_o !== 1'b0 || busy_o !== 1'b0) begin
         errors++; $display("FAIL sw_after: rsp_vld=%b busy=%b required 0 0", rsp_vld_o, busy_o);
      end
   endtask

   task automatic test_wait_read();
      cmd_t c;
      logic ok, got, seen, unstable, wd_bad;
      rsp_t r, rh, e;
      int pen;
      c = '{write: 1'b0, addr: 6'h3C, wdata: 32'hDEADBEEF, wt: 3};
      send_cmd(c, ok);
      cmd_vld_i = 1'b0;
      pen = 0; seen = 1'b0; unstable = 1'b0; wd_bad = 1'b0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (apb_psel_m) begin
            seen = 1'b1;
            if (apb_paddr_m !== 6'h3C) unstable = 1'b1;
            if (apb_pwdata_m !== '0) wd_bad = 1'b1;
            if (apb_penable_m) pen++;
         end else if (seen) break;
      end
      checks++;
      if (ok !== 1'b1 || pen != 4) begin errors++; $display("FAIL wr_penable_cycles: got %0d required 4", pen); end
      checks++;
      if (unstable !== 1'b0) begin errors++; $display("FAIL wr_paddr_stable: got unstable=%b required 0", unstable); end
      checks++;
      if (wd_bad !== 1'b0) begin errors++; $display("FAIL wr_pwdata_zero: got %b required 0", wd_bad); end
      get_rsp(1, got, r, rh);
      e = exp_q.pop_front();
      checks++;
      if (got !== 1'b1 || r !== e || r.rdata !== 32'h1) begin
         errors++; $display("FAIL wr_rsp: got %h required %h", r, e);
      end
   endtask

   task automatic test_fifo_backpressure();
      cmd_t c[6];
      logic ok, ok6;
      logic got[6];
      rsp_t r[6];
      rsp_t rh;
      rsp_t e;
      int base, bad;
      base = int'($urandom % 64);
      for (int i = 0; i < 6; i++)
         c[i] = '{write: 1'b0, addr: AW'((base + i * 5) % 64), wdata: $urandom, wt: $urandom % 3};
      bus_addr_q.delete();
      rsp_rdy_i = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         if (!cmd_rdy_o) bad++;
         send_cmd(c[i], ok);
         if (!ok) bad++;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ff_first5: got %0d stalls required 0", bad); end
      cmd_vld_i = 1'b1; cmd_write_i = c[5].write; cmd_addr_i = c[5].addr; cmd_wdata_i = c[5].wdata;
      repeat (4) tick();
      checks++;
      if (cmd_rdy_o !== 1'b0) begin errors++; $display("FAIL ff_full_rdy: got %b required 0", cmd_rdy_o); end
      checks++;
      if (rsp_vld_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++; $display("FAIL ff_pending: rsp_vld=%b busy=%b required 1 1", rsp_vld_o, busy_o);
      end
      fork
         begin
            send_cmd(c[5], ok6);
            cmd_vld_i = 1'b0;
         end
         begin
            for (int i = 0; i < 6; i++) get_rsp(0, got[i], r[i], rh);
         end
      join
      checks++;
      if (ok6 !== 1'b1) begin errors++; $display("FAIL ff_sixth_accept: got %b required 1", ok6); end
      for (int i = 0; i < 6; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (got[i] !== 1'b1 || r[i] !== e) begin
            errors++; $display("FAIL ff_rsp%0d: got %h required %h", i, r[i], e);
         end
      end
      bad = 0;
      if (bus_addr_q.size() != 6) bad = 99;
      else for (int i = 0; i < 6; i++) if (bus_addr_q[i] !== c[i].addr) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL ff_addr_order: got %0d mismatched required 0", bad); end
   endtask

   task automatic test_timeout();
      cmd_t c0, c1;
      logic ok0, ok1, got, seen;
      rsp_t r, rh, e;
      int pen;
      c0 = '{write: 1'b0, addr: AW'($urandom), wdata: $urandom, wt: 100};
      c1 = '{write: 1'b0, addr: AW'($urandom), wdata: $urandom, wt: 1};
      send_cmd(c0, ok0);
      send_cmd(c1, ok1);
      cmd_vld_i = 1'b0;
      pen = 0; seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (apb_penable_m) begin pen++; seen = 1'b1; end
         else if (seen) break;
      end
      checks++;
      if (ok0 !== 1'b1 || ok1 !== 1'b1 || pen != TO) begin
         errors++; $display("FAIL to_penable_cycles: got %0d required %0d", pen, TO);
      end
      get_rsp(0, got, r, rh);
      e = exp_q.pop_front();
      checks++;
      if (got !== 1'b1 || r !== e || r.timeout !== 1'b1 || r.rdata !== '0) begin
         errors++; $display("FAIL to_rsp: got %h required %h", r, e);
      end
      get_rsp(0, got, r, rh);
      e = exp_q.pop_front();
      checks++;
      if (got !== 1'b1 || r !== e || r.timeout !== 1'b0) begin
         errors++; $display("FAIL to_next_rsp: got %h required %h", r, e);
      end
   endtask

   task automatic test_priority();
      cmd_t c;
      logic ok, got, seen;
      rsp_t r, rh, e;
      int pen;
      c = '{write: 1'b0, addr: AW'($urandom), wdata: $urandom, wt: TO - 1};
      send_cmd(c, ok);
      cmd_vld_i = 1'b0;
      pen = 0; seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (apb_penable_m) begin pen++; seen = 1'b1; end
         else if (seen) break;
      end
      checks++;
      if (ok !== 1'b1 || pen != TO) begin errors++; $display("FAIL pri_penable_cycles: got %0d required %0d", pen, TO); end
      get_rsp(0, got, r, rh);
      e = exp_q.pop_front();
      checks++;
      if (got !== 1'b1 || r !== e || r.timeout !== 1'b0) begin
         errors++; $display("FAIL pri_rsp: got %h required %h", r, e);
      end
   endtask

   task automatic test_random();
      localparam int N = 40;
      cmd_t cs[N];
      int bad;
      for (int k = 0; k < N; k++)
         cs[k] = '{write: 1'($urandom & 1), addr: AW'($urandom), wdata: $urandom, wt: $urandom % 10};
      bus_addr_q.delete();
      noise_en = 1'b1;
      fork
         begin
            logic ok;
            int idle;
            for (int k = 0; k < N; k++) begin
               idle = int'($urandom % 3);
               if (idle != 0) begin
                  cmd_vld_i = 1'b0;
                  repeat (idle) tick();
               end
               send_cmd(cs[k], ok);
               checks++;
               if (ok !== 1'b1) begin errors++; $display("FAIL rnd_accept%0d: got %b required 1", k, ok); end
            end
            cmd_vld_i = 1'b0;
         end
         begin
            logic got;
            rsp_t r, rh, e;
            for (int k = 0; k < N; k++) begin
               get_rsp(int'($urandom % 3), got, r, rh);
               e = exp_q.pop_front();
               checks++;
               if (got !== 1'b1 || r !== e) begin
                  errors++; $display("FAIL rnd_rsp%0d: got %h required %h", k, r, e);
               end
               checks++;
               if (rh !== r) begin
                  errors++; $display("FAIL rnd_stable%0d: got %h required %h", k, rh, r);
               end
            end
         end
      join
      noise_en = 1'b0;
      bad = 0;
      if (bus_addr_q.size() != N) bad = 999;
      else for (int k = 0; k < N; k++) if (bus_addr_q[k] !== cs[k].addr) bad++;
      checks++;
      if (bad != 0) begin errors++; $display("FAIL rnd_addr_order: got %0d mismatched required 0", bad); end
   endtask

   task automatic test_reset_mid_access();
      cmd_t c;
      logic ok;
      int active;
      c = '{write: 1'b0, addr: AW'($urandom), wdata: $urandom, wt: 100};
      send_cmd(c, ok);
      c.addr = AW'($urandom); c.wt = 0;
      send_cmd(c, ok);
      c.write = 1'b1; c.addr = AW'($urandom);
      send_cmd(c, ok);
      cmd_vld_i = 1'b0;
      for (int i = 0; i < 20 && !apb_penable_m; i++) tick();
      checks++;
      if (apb_penable_m !== 1'b1) begin errors++; $display("FAIL rm_reach_access: got %b required 1", apb_penable_m); end
      #2;
      rst_n_i = 1'b0;
      #1;
      checks++;
      if ({apb_psel_m, apb_penable_m} !== 2'b00) begin
         errors++; $display("FAIL rm_async_drop: got %b required 00", {apb_psel_m, apb_penable_m});
      end
      @(posedge clk_i);
      @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
      exp_q.delete();
      wait_q.delete();
      bus_addr_q.delete();
      tick();
      checks++;
      if ({busy_o, rsp_vld_o, cmd_rdy_o} !== 3'b001) begin
         errors++; $display("FAIL rm_after_release: got busy,rsp_vld,cmd_rdy=%b required 001", {busy_o, rsp_vld_o, cmd_rdy_o});
      end
      active = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (apb_psel_m || apb_penable_m || rsp_vld_o) active++;
      end
      checks++;
      if (active != 0 || bus_addr_q.size() != 0) begin
         errors++; $display("FAIL rm_no_activity: got %0d active cycles required 0", active);
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) model_mem[i] = init_val(i);
      test_reset();
      test_single_write();
      test_wait_read();
      test_fifo_backpressure();
      test_timeout();
      test_priority();
      test_random();
      test_reset_mid_access();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
